// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: drives a shared 32-bit ALU (ADD/SUB/AND/OR) one request
// at a time. ADD/SUB/AND/OR take a single ALU pass. MUL is a shift-and-add
// loop on the ALU ADD path that always runs MUL_BITS iterations.
module alu_op_sequencer #(
    parameter int MUL_BITS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [3:0]  rsp_flags,
    output logic        rsp_err,
    output logic [3:0]  cpsr_flags,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [1:0]  alu_func,
    input  logic [31:0] alu_out,
    input  logic        alu_c,
    input  logic        alu_z,
    input  logic        alu_n,
    input  logic        alu_v
);

    localparam int CW = $clog2(MUL_BITS + 1);
    localparam logic [CW-1:0] COUNT_LAST = CW'(MUL_BITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [1:0]    func;
    logic [31:0]   opa;
    logic [31:0]   opb;
    logic [31:0]   acc;
    logic [31:0]   mcand;
    logic [31:0]   mplier;
    logic [CW-1:0] count;

    logic          mul_last;
    logic [31:0]   acc_next;
    logic          op_legal;
    logic          op_mul;

    // MUL produces its own flags: the ALU carry/overflow of the partial sums
    // mean nothing for the product, so only N and Z are reported.
    function automatic logic [3:0] mul_flags(input logic [31:0] result);
        return {result[31], (result == 32'd0), 1'b0, 1'b0};
    endfunction

    assign mul_last = (count == COUNT_LAST);
    assign acc_next = mplier[0] ? alu_out : acc;
    assign op_legal = (req_op <= 3'd4);
    assign op_mul   = (req_op == 3'd4);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    if (!op_legal) begin
                        state_next = DONE;
                    end else if (op_mul) begin
                        state_next = MUL;
                    end else begin
                        state_next = EXEC;
                    end
                end
            end
            EXEC: state_next = DONE;
            MUL: begin
                if (mul_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake and ALU drive derived from the current state.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        alu_a     = 32'd0;
        alu_b     = 32'd0;
        alu_func  = 2'b00;
        unique case (state)
            IDLE: req_ready = 1'b1;
            EXEC: begin
                alu_a    = opa;
                alu_b    = opb;
                alu_func = func;
            end
            MUL: begin
                alu_a    = acc;
                alu_b    = mcand;
                alu_func = 2'b00;
            end
            DONE: rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand latch, multiply loop, response capture and CPSR update.
    always_ff @(posedge clk) begin
        if (rst) begin
            func       <= 2'b00;
            opa        <= 32'd0;
            opb        <= 32'd0;
            acc        <= 32'd0;
            mcand      <= 32'd0;
            mplier     <= 32'd0;
            count      <= '0;
            rsp_result <= 32'd0;
            rsp_flags  <= 4'd0;
            rsp_err    <= 1'b0;
            cpsr_flags <= 4'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        func <= req_op[1:0];
                        opa  <= req_a;
                        opb  <= req_b;
                        if (op_mul) begin
                            acc    <= 32'd0;
                            mcand  <= req_a;
                            mplier <= req_b;
                            count  <= '0;
                        end
                        if (!op_legal) begin
                            rsp_result <= 32'd0;
                            rsp_flags  <= 4'd0;
                            rsp_err    <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    rsp_result <= alu_out;
                    rsp_flags  <= {alu_n, alu_z, alu_c, alu_v};
                    rsp_err    <= 1'b0;
                end
                MUL: begin
                    acc    <= acc_next;
                    mcand  <= {mcand[30:0], 1'b0};
                    mplier <= {1'b0, mplier[31:1]};
                    count  <= count + CW'(1);
                    if (mul_last) begin
                        rsp_result <= acc_next;
                        rsp_flags  <= mul_flags(acc_next);
                        rsp_err    <= 1'b0;
                    end
                end
                DONE: begin
                    if (rsp_ready && !rsp_err) begin
                        cpsr_flags <= rsp_flags;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
